// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults and helpers for the reg_pipe register pipeline.
// Optional feature macro: REG_PIPE_PARITY_EN (per-byte even parity carried per stage).
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 72;
    localparam int DEFAULT_DEPTH = 3;

    // Width needed to hold a stage count from 0 to depth inclusive.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Even parity of one byte: the bit that makes the total number of ones even.
    function automatic logic evenParity(input logic [7:0] dataByte);
        return ^dataByte;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one pipeline slot holding a data word, a valid bit and,
// when REG_PIPE_PARITY_EN is defined, one even-parity bit per data byte.
// A load copies the source valid bit; the data (and parity) are only
// overwritten when the source actually carries a beat.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_i,
    input  logic             srcValid_i,
    input  logic [WIDTH-1:0] srcData_i,
`ifdef REG_PIPE_PARITY_EN
    input  logic [WIDTH/8-1:0] srcPar_i,
    output logic [WIDTH/8-1:0] par_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state: take the source valid on a load, keep old data when the source is a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = srcValid_i;
            if (srcValid_i) begin
                data_d = srcData_i;
            end
        end
    end

    // Slot registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef REG_PIPE_PARITY_EN
    logic [WIDTH/8-1:0] par_q, par_d;

    // Parity follows the data word it was generated for.
    always_comb begin
        par_d = par_q;
        if (load_i && srcValid_i) begin
            par_d = srcPar_i;
        end
    end

    // Parity registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_o = par_q;
`endif

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse,
// global clock enable, synchronous clear and a registered occupancy count.
// Optional feature macro: REG_PIPE_PARITY_EN adds per-byte even parity that is
// generated at the input and checked on every output transfer (sticky par_err).
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       ce,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic [cntWidth(DEPTH)-1:0] count,
    output logic                       par_err
);

    localparam int CW = cntWidth(DEPTH);

    logic [DEPTH-1:0] stValid;
    logic [DEPTH-1:0] srcValid;
    logic [DEPTH-1:0] loadEn;
    logic [WIDTH-1:0] stData  [DEPTH];
    logic [WIDTH-1:0] srcData [DEPTH];

    logic          inFire;
    logic          outFire;
    logic [CW-1:0] count_q, count_d;

    // A stage loads when any stage at or beyond it has a hole, or the output drains;
    // scanning from the output end avoids a combinational loop through loadEn.
    always_comb begin : loadScan
        logic hole;
        hole   = out_ready;
        loadEn = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hole      = hole | ~stValid[i];
            loadEn[i] = ce & ~clr & hole;
        end
    end

    assign in_ready  = loadEn[0];
    assign out_valid = stValid[DEPTH-1];
    assign q         = stData[DEPTH-1];
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready & ce & ~clr;

`ifdef REG_PIPE_PARITY_EN
    logic [WIDTH/8-1:0] stPar  [DEPTH];
    logic [WIDTH/8-1:0] srcPar [DEPTH];
    logic [WIDTH/8-1:0] dPar;
    logic [WIDTH/8-1:0] qPar;

    for (genvar b = 0; b < WIDTH / 8; b++) begin : gPar
        assign dPar[b] = evenParity(d[8*b +: 8]);
        assign qPar[b] = evenParity(q[8*b +: 8]);
    end
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : gStage
        if (i == 0) begin : gSrcIn
            assign srcValid[i] = in_valid;
            assign srcData[i]  = d;
`ifdef REG_PIPE_PARITY_EN
            assign srcPar[i]   = dPar;
`endif
        end else begin : gSrcPrev
            assign srcValid[i] = stValid[i-1];
            assign srcData[i]  = stData[i-1];
`ifdef REG_PIPE_PARITY_EN
            assign srcPar[i]   = stPar[i-1];
`endif
        end

        reg_pipe_stage #(
            .WIDTH (WIDTH)
        ) uStage (
            .clk        (clk),
            .clr        (clr),
            .load_i     (loadEn[i]),
            .srcValid_i (srcValid[i]),
            .srcData_i  (srcData[i]),
`ifdef REG_PIPE_PARITY_EN
            .srcPar_i   (srcPar[i]),
            .par_o      (stPar[i]),
`endif
            .valid_o    (stValid[i]),
            .data_o     (stData[i])
        );
    end

    // Occupancy moves by one only when exactly one side of the pipe transfers.
    always_comb begin
        count_d = count_q;
        if (inFire && !outFire) begin
            count_d = count_q + 1'b1;
        end else if (outFire && !inFire) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef REG_PIPE_PARITY_EN
    logic parErr_q, parErr_d;

    // Latch any parity mismatch seen on a beat leaving the pipe.
    always_comb begin
        parErr_d = parErr_q;
        if (outFire && (qPar != stPar[DEPTH-1])) begin
            parErr_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            parErr_q <= 1'b0;
        end else begin
            parErr_q <= parErr_d;
        end
    end

    assign par_err = parErr_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 72, data width in bits; legal values are multiples of 8 from 8 to 512.
REQ-002 The block SHALL have parameter DEPTH, default 3, number of register stages; legal values are 1 to 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port ce, input, 1 bit: global clock enable; low freezes all state.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the beat is accepted this cycle.
REQ-008 The block SHALL have port d, input, WIDTH bits: upstream data.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the last stage holds a beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 The block SHALL have port q, output, WIDTH bits: last-stage data.
REQ-012 The block SHALL have port count, output, clog2(DEPTH+1) bits: number of valid stages.
REQ-013 The block SHALL have port par_err, output, 1 bit: parity error flag (see Configuration).

Function
REQ-014 Each stage SHALL hold a data register and a valid bit; stage 0 is fed from d and stage DEPTH-1 drives q and out_valid.
REQ-015 Stage i SHALL load on a clk edge when ce=1 and (stage i is empty or stage i advances).
REQ-016 The last stage advances when out_ready=1; stage i<DEPTH-1 advances when stage i+1 loads.
REQ-017 in_ready SHALL equal ce AND (stage 0 empty OR stage 0 advances); the path is combinational and bubbles collapse.
REQ-018 A beat SHALL transfer only when valid and ready are both 1 in the same cycle; no beat is lost or duplicated.
REQ-019 A stage that loads while its source is invalid SHALL clear its valid bit and retain its data.
REQ-020 Latency SHALL be DEPTH edges from acceptance to out_valid when the pipe is unstalled; sustained throughput SHALL be 1 beat per cycle with out_ready held at 1.
REQ-021 When out_ready=0 and all stages are valid, in_ready SHALL be 0 and q SHALL hold stable.
REQ-022 count SHALL be registered and SHALL equal the number of valid bits after each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither.
REQ-023 With ce=0, no register SHALL change, in_ready SHALL be 0, and out_valid and q SHALL hold; the downstream SHALL NOT consume a beat while ce=0.

Reset
REQ-024 While clr=1 at an edge, all valid bits SHALL clear, count SHALL become 0, par_err SHALL become 0, and data registers SHALL become 0.
REQ-025 clr SHALL take priority over ce and over any simultaneous transfer; a beat presented in the clr cycle SHALL be discarded and in_ready SHALL be 0 while clr=1.
REQ-026 clr asserted mid-stream SHALL flush all in-flight beats; out_valid SHALL be 0 on the first cycle after the clr edge.

Configuration
REQ-027 With macro REG_PIPE_PARITY_EN defined, each stage SHALL carry WIDTH/8 even-parity bits generated from d at stage 0.
REQ-028 With REG_PIPE_PARITY_EN defined, parity SHALL be checked at q on each output transfer, and par_err SHALL be set sticky on a mismatch and cleared only by clr.
REQ-029 Without REG_PIPE_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied to 0.

Structure
REQ-030 Package reg_pipe_pkg SHALL hold the default WIDTH and DEPTH, the count-width function, and the parity-generate function.
REQ-031 A sub-module reg_pipe_stage (data, valid, optional parity, load enable) SHALL be instantiated DEPTH times via generate.

Verification
REQ-032 Fill/drain (WIDTH=72, DEPTH=3, ce=1, out_ready=1): push 72'hFF then 72'hAA -> q=FF after 3 edges, then AA on the next edge; count goes 1,2,2,1,0 as the beats drain.
REQ-033 Backpressure: out_ready=0 with 4 beats 01..04 offered -> 3 are accepted, in_ready=0, count=3; release out_ready -> output order 01,02,03,04 with no gaps.
REQ-034 ce freeze: drop ce for 5 cycles mid-stream with out_ready=1 -> q, out_valid, and count are unchanged and in_ready=0; the stream resumes intact.
REQ-035 clr priority: assert clr with ce=1, in_valid=1, and a full pipe -> next cycle out_valid=0, count=0, and the offered beat is absent from later output.
REQ-036 Bubble collapse: insert a single beat, stall out_ready=0, then push 2 more -> count reaches 3 with no empty stage between beats.
REQ-037 Parity (REG_PIPE_PARITY_EN defined): force-flip bit 0 of stage 1 data -> par_err=1 on the transfer, stays 1 until clr; without the macro par_err stays 0.
